// File: rtl/coffee_brew_scheduler.sv
// Shared brew-unit scheduler for a two-station coffee machine:
// per-station drink queues, round-robin grant, grind/brew/clean sequencing.
module coffee_brew_scheduler #(
  parameter int GRIND_CYC = 4,
  parameter int BREW_CYC  = 8,
  parameter int CLEAN_CYC = 2,
  parameter int MAX_PEND  = 3,
  parameter int PW        = $clog2(MAX_PEND + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cafea_a,
  input  logic          cafea_b,
  output logic          grinder,
  output logic          pump,
  output logic          valve_a,
  output logic          valve_b,
  output logic          flush,
  output logic          served_a,
  output logic          served_b,
  output logic          busy,
  output logic [PW-1:0] pend_a,
  output logic [PW-1:0] pend_b,
  output logic          overflow_a,
  output logic          overflow_b
);

  localparam int MAXC0 = (GRIND_CYC > BREW_CYC) ? GRIND_CYC : BREW_CYC;
  localparam int MAXC  = (MAXC0 > CLEAN_CYC) ? MAXC0 : CLEAN_CYC;
  localparam int TW    = $clog2(MAXC + 1);

  localparam logic [TW-1:0] G_LD = TW'(GRIND_CYC - 1);
  localparam logic [TW-1:0] B_LD = TW'(BREW_CYC - 1);
  localparam logic [TW-1:0] C_LD = TW'(CLEAN_CYC - 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, GRIND, BREW, CLEAN} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [PW-1:0]   pa_q, pa_d;
  logic [PW-1:0]   pb_q, pb_d;
  logic            ova_q, ova_d;
  logic            ovb_q, ovb_d;
  logic            grant_a, grant_b;

  // On a tie the station that was not served last wins (last: 0=A, 1=B).
  always_comb begin
    grant_a = (state_q == IDLE) && (pa_q != '0) &&
              ((pb_q == '0) || last_q);
    grant_b = (state_q == IDLE) && (pb_q != '0) &&
              ((pa_q == '0) || !last_q);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_d = GRIND;
          timer_d = G_LD;
          owner_d = grant_b;
          last_d  = grant_b;
        end
      end
      GRIND: begin
        if (timer_q == '0) begin
          state_d = BREW;
          timer_d = B_LD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      BREW: begin
        if (timer_q == '0) begin
          state_d = CLEAN;
          timer_d = C_LD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      CLEAN: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Request and grant on the same edge cancel; a full queue drops the request.
  always_comb begin
    pa_d  = pa_q;
    pb_d  = pb_q;
    ova_d = ova_q;
    ovb_d = ovb_q;
    if (cafea_a && !grant_a) begin
      if (pa_q == PMAX) ova_d = 1'b1;
      else              pa_d  = pa_q + PW'(1);
    end else if (!cafea_a && grant_a) begin
      pa_d = pa_q - PW'(1);
    end
    if (cafea_b && !grant_b) begin
      if (pb_q == PMAX) ovb_d = 1'b1;
      else              pb_d  = pb_q + PW'(1);
    end else if (!cafea_b && grant_b) begin
      pb_d = pb_q - PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      pa_q    <= '0;
      pb_q    <= '0;
      ova_q   <= 1'b0;
      ovb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      ova_q   <= ova_d;
      ovb_q   <= ovb_d;
    end
  end

  assign grinder    = (state_q == GRIND);
  assign pump       = (state_q == BREW);
  assign valve_a    = (state_q == BREW) && !owner_q;
  assign valve_b    = (state_q == BREW) && owner_q;
  assign flush      = (state_q == CLEAN);
  assign served_a   = (state_q == CLEAN) && (timer_q == C_LD) && !owner_q;
  assign served_b   = (state_q == CLEAN) && (timer_q == C_LD) && owner_q;
  assign busy       = (state_q != IDLE);
  assign pend_a     = pa_q;
  assign pend_b     = pb_q;
  assign overflow_a = ova_q;
  assign overflow_b = ovb_q;

endmodule

// File: tb/tb_coffee_brew_scheduler.sv
// Bench for coffee_brew_scheduler: timeline table, served-order
// scoreboard and hand-written corner sequences.
module tb_coffee_brew_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cafea_a = 1'b0;
  logic       cafea_b = 1'b0;
  logic       grinder, pump, valve_a, valve_b, flush;
  logic       served_a, served_b, busy;
  logic [1:0] pend_a, pend_b;
  logic       overflow_a, overflow_b;

  coffee_brew_scheduler dut (
    .clock(clock), .reset(reset),
    .cafea_a(cafea_a), .cafea_b(cafea_b),
    .grinder(grinder), .pump(pump),
    .valve_a(valve_a), .valve_b(valve_b),
    .flush(flush), .served_a(served_a), .served_b(served_b),
    .busy(busy), .pend_a(pend_a), .pend_b(pend_b),
    .overflow_a(overflow_a), .overflow_b(overflow_b)
  );

  always #5 clock = ~clock;

  logic [7:0] outs;
  assign outs = {grinder, pump, valve_a, valve_b,
                 flush, busy, served_a, served_b};

  int n_checks = 0;
  int n_fail   = 0;
  int sbq[$];

  typedef struct {
    int         lo;
    int         hi;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Served-station scoreboard: 0 = A, 1 = B.
  always @(negedge clock) begin
    if (!reset && (served_a || served_b)) begin
      if (served_a && served_b) begin
        chk("served_both", 1, 0);
      end else if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL served_unexpected: got station %0d expected none",
                 served_b ? 1 : 0);
      end else begin
        chk("served_station", served_b ? 1 : 0, sbq.pop_front());
      end
    end
  end

  task automatic wait_served(input int budget, output int cyc);
    cyc = 0;
    while (sbq.size() != 0 && cyc < budget) begin
      @(negedge clock);
      #1;
      cyc++;
    end
    chk("served_timeout_left", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk("idle_timeout_busy", int'(busy), 0);
  endtask

  task automatic do_reset();
    cafea_a = 1'b0;
    cafea_b = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  vec_t tbl[6];
  int   cyc;

  initial begin
    tbl[0] = '{0,  0,  8'b0000_0000};
    tbl[1] = '{1,  4,  8'b1000_0100};
    tbl[2] = '{5,  12, 8'b0110_0100};
    tbl[3] = '{13, 13, 8'b0000_1110};
    tbl[4] = '{14, 14, 8'b0000_1100};
    tbl[5] = '{15, 16, 8'b0000_0000};

    // Reset state
    #1;
    chk("rst_outs", int'(outs), 0);
    chk("rst_pend_a", int'(pend_a), 0);
    chk("rst_pend_b", int'(pend_b), 0);
    chk("rst_ovf", int'({overflow_a, overflow_b}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Single A request timeline
    sbq.push_back(0);
    @(posedge clock); #1 cafea_a = 1'b1;
    @(posedge clock); #1 cafea_a = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clock);
      if (k == 0) chk("single_pend_a", int'(pend_a), 1);
      for (int e = 0; e < 6; e++)
        if (k >= tbl[e].lo && k <= tbl[e].hi)
          chk($sformatf("single_outs_c%0d", k), int'(outs),
              int'(tbl[e].exp));
    end
    wait_served(5, cyc);

    // Tie after reset: A first, B granted at E16
    do_reset();
    sbq.push_back(0);
    sbq.push_back(1);
    @(posedge clock); #1 begin cafea_a = 1'b1; cafea_b = 1'b1; end
    @(posedge clock); #1 begin cafea_a = 1'b0; cafea_b = 1'b0; end
    for (int k = 0; k <= 28; k++) begin
      @(negedge clock);
      if (k == 5 || k == 12 || k == 13 || k == 4)
        chk($sformatf("tie_valve_a_c%0d", k), int'(valve_a),
            (k >= 5 && k <= 12) ? 1 : 0);
      if (k == 19 || k == 20 || k == 27 || k == 28)
        chk($sformatf("tie_valve_b_c%0d", k), int'(valve_b),
            (k >= 20 && k <= 27) ? 1 : 0);
    end
    wait_served(5, cyc);
    wait_idle(5);

    // Three drinks per station, alternating service
    do_reset();
    repeat (3) begin
      sbq.push_back(0);
      sbq.push_back(1);
    end
    @(posedge clock); #1 begin cafea_a = 1'b1; cafea_b = 1'b1; end
    repeat (3) @(posedge clock);
    #1 begin cafea_a = 1'b0; cafea_b = 1'b0; end
    wait_served(100, cyc);
    chk("six_within_90", int'((cyc + 2) <= 90), 1);
    wait_idle(5);
    chk("six_pend_a", int'(pend_a), 0);
    chk("six_pend_b", int'(pend_b), 0);

    // Saturation of station A during one drink
    do_reset();
    repeat (4) sbq.push_back(0);
    @(posedge clock); #1 cafea_a = 1'b1;
    @(posedge clock); #1 cafea_a = 1'b0;
    repeat (5) begin
      @(posedge clock); #1 cafea_a = 1'b1;
      @(posedge clock); #1 cafea_a = 1'b0;
    end
    @(negedge clock);
    chk("sat_busy", int'(busy), 1);
    chk("sat_pend_a", int'(pend_a), 3);
    chk("sat_ovf_a", int'(overflow_a), 1);
    chk("sat_ovf_b", int'(overflow_b), 0);
    wait_served(70, cyc);
    wait_idle(5);
    chk("sat_ovf_a_sticky", int'(overflow_a), 1);
    chk("sat_pend_a_drained", int'(pend_a), 0);

    // Request on the grant edge
    sbq.push_back(0);
    sbq.push_back(0);
    @(posedge clock); #1 cafea_a = 1'b1;
    @(posedge clock);
    @(posedge clock); #1 cafea_a = 1'b0;
    @(negedge clock);
    chk("grant_edge_pend_a", int'(pend_a), 1);
    chk("grant_edge_grinder", int'(grinder), 1);
    wait_served(40, cyc);
    wait_idle(5);

    // Reset during the third BREW cycle
    do_reset();
    @(posedge clock); #1 cafea_b = 1'b1;
    repeat (3) @(posedge clock);
    #1 cafea_b = 1'b0;
    @(negedge clock);
    chk("abort_pend_b_pre", int'(pend_b), 2);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("abort_pump_pre", int'(valve_b), 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_outs", int'(outs), 0);
    chk("abort_pend_b", int'(pend_b), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sbq.push_back(0);
    sbq.push_back(1);
    @(posedge clock); #1 begin cafea_a = 1'b1; cafea_b = 1'b1; end
    @(posedge clock); #1 begin cafea_a = 1'b0; cafea_b = 1'b0; end
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_pend_a", int'(pend_a), 0);
    chk("post_rst_pend_b", int'(pend_b), 1);
    wait_served(40, cyc);
    wait_idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
